// File: rtl/mem_pkg.sv
// mem_pkg: shared cache FSM states and funct3 access-size encodings
package mem_pkg;
  typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_e;
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
endpackage

// File: rtl/lsu_align.sv
// lsu_align: load byte/half extraction with extension and store byte-lane steering
module lsu_align
  import mem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] line,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [31:0] lane_wdata,
  output logic [3:0]  lane_wstrb
);
  logic       is_b, is_h, uns;
  logic [7:0]  sel_b;
  logic [15:0] sel_h;
  always_comb begin
    is_b = funct3 == F3_LB || funct3 == F3_LBU;
    is_h = funct3 == F3_LH || funct3 == F3_LHU;
    uns = funct3 == F3_LBU || funct3 == F3_LHU;
    sel_b = line[8*off +: 8];
    sel_h = off[1] ? line[31:16] : line[15:0];
    rdata = is_b ? {{24{sel_b[7] & ~uns}}, sel_b} : is_h ? {{16{sel_h[15] & ~uns}}, sel_h} : line;
    lane_wdata = is_b ? {4{wdata[7:0]}} : is_h ? {2{wdata[15:0]}} : wdata;
    lane_wstrb = is_b ? 4'b0001 << off : is_h ? (off[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  end
endmodule

// File: rtl/mem_dcache.sv
// mem_dcache: direct-mapped one-word-line write-through data cache for the MEM stage
module mem_dcache
  import mem_pkg::*;
#(
  parameter int SETS = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        re,
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);
  localparam int IW = $clog2(SETS);
  localparam int TW = 30 - IW;
  state_e state_q, state_d;
  logic [SETS-1:0] valid_q;
  logic [TW-1:0]   tag_q [SETS];
  logic [31:0]     data_q [SETS];
  logic [31:2]     addr_q;
  logic [31:0]     wdata_q, lane_wdata;
  logic [3:0]      wstrb_q, lane_wstrb;
  logic [IW-1:0]   idx, idx_q;
  logic            hit, hit_q;
  assign idx = addr[IW+1:2];
  assign idx_q = addr_q[IW+1:2];
  assign hit = valid_q[idx] && tag_q[idx] == addr[31:IW+2];
  assign hit_q = valid_q[idx_q] && tag_q[idx_q] == addr_q[31:IW+2];
  assign mem_addr = {addr_q, 2'b00};
  assign mem_wdata = wdata_q;
  assign mem_wstrb = wstrb_q;
  lsu_align u_align (
    .funct3    (funct3),
    .off       (addr[1:0]),
    .line      (data_q[idx]),
    .wdata     (wdata),
    .rdata     (rdata),
    .lane_wdata(lane_wdata),
    .lane_wstrb(lane_wstrb)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q == IDLE ? (we ? WRITE : (re && !hit) ? FILL : IDLE) :
              state_q == DONE ? IDLE : mem_ack ? DONE : state_q;
  end
  always_comb begin
    stall = state_q == IDLE ? (we || (re && !hit)) : state_q != DONE;
    mem_req = state_q == FILL || state_q == WRITE;
    mem_we = state_q == WRITE;
  end
  // request fields are captured while idle so they stay frozen for the whole transaction
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      valid_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else begin
      if (state_q == IDLE) begin
        addr_q <= addr[31:2];
        wdata_q <= lane_wdata;
        wstrb_q <= lane_wstrb;
      end
      if (state_q == FILL && mem_ack) valid_q[idx_q] <= 1'b1;
    end
  always_ff @(posedge clk) begin
    if (!rst && mem_ack && state_q == FILL) begin
      data_q[idx_q] <= mem_rdata;
      tag_q[idx_q] <= addr_q[31:IW+2];
    end
    if (!rst && mem_ack && state_q == WRITE && hit_q)
      for (int i = 0; i < 4; i++)
        if (wstrb_q[i]) data_q[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
  end
endmodule

// File: tb/tb_mem_dcache.sv
// tb_mem_dcache: table-driven cache vectors with a backing-memory scoreboard
module tb_mem_dcache;
  import mem_pkg::*;
  logic clk = 0, rst = 1, re = 0, we = 0, mem_ack = 0;
  logic [2:0] funct3 = 0;
  logic [31:0] addr = 0, wdata = 0, mem_rdata = 0, rdata, mem_addr, mem_wdata;
  logic stall, mem_req, mem_we;
  logic [3:0] mem_wstrb;
  int checks = 0, failures = 0, ack_dly = 1;
  logic [31:0] mem [int unsigned];
  typedef struct { logic we; logic [31:0] addr; logic [3:0] strb; logic [31:0] wd; } txn_t;
  typedef struct {
    string nm; logic re, we; logic [2:0] f3; logic [31:0] addr, wdata;
    int dly, stalls; logic chk; logic [31:0] rd; logic txn; logic [3:0] strb; logic [31:0] mwd;
  } vec_t;
  txn_t txn_q[$];
  logic [31:0] rd_q[$];
  vec_t vt[$];

  mem_dcache #(.SETS(64)) dut (
    .clk(clk), .rst(rst), .re(re), .we(we), .funct3(funct3), .addr(addr), .wdata(wdata),
    .rdata(rdata), .stall(stall), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  // backing memory: acks after ack_dly request cycles, checks each request against the queue
  initial begin : responder
    int cnt;
    txn_t cur;
    logic [31:0] w;
    cnt = 0;
    forever begin
      @(posedge clk); #1;
      mem_ack = 0;
      if (!mem_req) cnt = 0;
      else begin
        if (cnt == 0) begin
          if (txn_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_req: got request addr %h we %b, expected none", mem_addr, mem_we);
            cur = '{mem_we, mem_addr, mem_wstrb, mem_wdata};
          end else begin
            cur = txn_q.pop_front();
            chk("req_we", mem_we, cur.we);
            chk("req_addr", mem_addr, cur.addr);
            if (cur.we) begin
              chk("req_wstrb", mem_wstrb, cur.strb);
              chk("req_wdata", mem_wdata, cur.wd);
            end
          end
        end else begin
          chk("req_stable_addr", mem_addr, cur.addr);
          if (cur.we) chk("req_stable_wdata", mem_wdata, cur.wd);
        end
        cnt++;
        if (cnt == ack_dly) begin
          mem_ack = 1;
          if (mem_we) begin
            w = mem_rd(mem_addr);
            for (int i = 0; i < 4; i++) if (mem_wstrb[i]) w[8*i +: 8] = mem_wdata[8*i +: 8];
            mem[mem_addr] = w;
          end else mem_rdata = mem_rd(mem_addr);
        end
      end
    end
  end

  task automatic run(input vec_t v);
    int st;
    bit done;
    logic [31:0] rdv, exp;
    logic mreq;
    st = 0; done = 0; rdv = 0; mreq = 0;
    ack_dly = v.dly;
    if (v.txn) txn_q.push_back('{v.we, v.addr & 32'hFFFF_FFFC, v.strb, v.mwd});
    if (v.chk) rd_q.push_back(v.rd);
    re = v.re; we = v.we; funct3 = v.f3; addr = v.addr; wdata = v.wdata;
    for (int c = 0; c < 64 && !done; c++) begin
      @(negedge clk);
      if (stall) st++;
      else begin
        done = 1; rdv = rdata; mreq = mem_req;
      end
      @(posedge clk); #1;
    end
    re = 0; we = 0;
    if (!done) begin
      checks++; failures++;
      $display("FAIL %s_timeout: stall still 1 after 64 cycles, required 0", v.nm);
    end else begin
      chk({v.nm, "_stall_cycles"}, st, v.stalls);
      chk({v.nm, "_mem_req_done"}, mreq, 0);
    end
    if (v.chk) begin
      exp = rd_q.pop_front();
      if (done) chk({v.nm, "_rdata"}, rdv, exp);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    mem[32'h100] = 32'hDEADBEEF;
    mem[32'h200] = 32'h12345678;
    mem[32'h500] = 32'hCAFEF00D;
    //          name          re we f3      addr       wdata        dly st chk rd            txn strb     mwd
    vt.push_back('{"lw_miss",     1, 0, F3_LW,  32'h100, 32'h0,        3, 4, 1, 32'hDEADBEEF, 1, 4'hF,    32'h0});
    vt.push_back('{"lw_hit",      1, 0, F3_LW,  32'h100, 32'h0,        1, 0, 1, 32'hDEADBEEF, 0, 4'h0,    32'h0});
    vt.push_back('{"lb_103",      1, 0, F3_LB,  32'h103, 32'h0,        1, 0, 1, 32'hFFFFFFDE, 0, 4'h0,    32'h0});
    vt.push_back('{"lbu_103",     1, 0, F3_LBU, 32'h103, 32'h0,        1, 0, 1, 32'h000000DE, 0, 4'h0,    32'h0});
    vt.push_back('{"lh_102",      1, 0, F3_LH,  32'h102, 32'h0,        1, 0, 1, 32'hFFFFDEAD, 0, 4'h0,    32'h0});
    vt.push_back('{"lhu_101",     1, 0, F3_LHU, 32'h101, 32'h0,        1, 0, 1, 32'h0000BEEF, 0, 4'h0,    32'h0});
    vt.push_back('{"lh_100",      1, 0, F3_LH,  32'h100, 32'h0,        1, 0, 1, 32'hFFFFBEEF, 0, 4'h0,    32'h0});
    vt.push_back('{"lb_100",      1, 0, F3_LB,  32'h100, 32'h0,        1, 0, 1, 32'hFFFFFFEF, 0, 4'h0,    32'h0});
    vt.push_back('{"lb_101",      1, 0, F3_LB,  32'h101, 32'h0,        1, 0, 1, 32'hFFFFFFBE, 0, 4'h0,    32'h0});
    vt.push_back('{"lbu_102",     1, 0, F3_LBU, 32'h102, 32'h0,        1, 0, 1, 32'h000000AD, 0, 4'h0,    32'h0});
    vt.push_back('{"sb_101",      0, 1, F3_LB,  32'h101, 32'h55,       1, 2, 0, 32'h0,        1, 4'b0010, 32'h55555555});
    vt.push_back('{"lw_after_sb", 1, 0, F3_LW,  32'h100, 32'h0,        1, 0, 1, 32'hDEAD55EF, 0, 4'h0,    32'h0});
    vt.push_back('{"sh_102",      0, 1, F3_LH,  32'h102, 32'h7001,     2, 3, 0, 32'h0,        1, 4'b1100, 32'h70017001});
    vt.push_back('{"lh_after_sh", 1, 0, F3_LH,  32'h102, 32'h0,        1, 0, 1, 32'h00007001, 0, 4'h0,    32'h0});
    vt.push_back('{"lw_after_sh", 1, 0, F3_LW,  32'h100, 32'h0,        1, 0, 1, 32'h700155EF, 0, 4'h0,    32'h0});
    vt.push_back('{"sw_miss_500", 0, 1, F3_LW,  32'h500, 32'h11223344, 2, 3, 0, 32'h0,        1, 4'hF,    32'h11223344});
    vt.push_back('{"lw_keep_100", 1, 0, F3_LW,  32'h100, 32'h0,        1, 0, 1, 32'h700155EF, 0, 4'h0,    32'h0});
    vt.push_back('{"lw_500_fill", 1, 0, F3_LW,  32'h500, 32'h0,        1, 2, 1, 32'h11223344, 1, 4'hF,    32'h0});
    vt.push_back('{"lw_100_refl", 1, 0, F3_LW,  32'h100, 32'h0,        1, 2, 1, 32'h700155EF, 1, 4'hF,    32'h0});
    vt.push_back('{"lw_200_evict",1, 0, F3_LW,  32'h200, 32'h0,        2, 3, 1, 32'h12345678, 1, 4'hF,    32'h0});
    vt.push_back('{"lw_100_miss", 1, 0, F3_LW,  32'h100, 32'h0,        1, 2, 1, 32'h700155EF, 1, 4'hF,    32'h0});
    vt.push_back('{"sb_100",      0, 1, F3_LB,  32'h100, 32'hAB,       1, 2, 0, 32'h0,        1, 4'b0001, 32'hABABABAB});
    vt.push_back('{"sb_103",      0, 1, F3_LB,  32'h103, 32'h80,       1, 2, 0, 32'h0,        1, 4'b1000, 32'h80808080});
    vt.push_back('{"lb_103_neg",  1, 0, F3_LB,  32'h103, 32'h0,        1, 0, 1, 32'hFFFFFF80, 0, 4'h0,    32'h0});
    vt.push_back('{"lh_102_neg",  1, 0, F3_LH,  32'h102, 32'h0,        1, 0, 1, 32'hFFFF8001, 0, 4'h0,    32'h0});
    vt.push_back('{"sh_100",      0, 1, F3_LH,  32'h100, 32'hFFFF1234, 1, 2, 0, 32'h0,        1, 4'b0011, 32'h12341234});
    vt.push_back('{"lhu_100",     1, 0, F3_LHU, 32'h100, 32'h0,        1, 0, 1, 32'h00001234, 0, 4'h0,    32'h0});
    vt.push_back('{"lhu_102",     1, 0, F3_LHU, 32'h102, 32'h0,        1, 0, 1, 32'h00008001, 0, 4'h0,    32'h0});
    vt.push_back('{"rew_sw_100",  1, 1, F3_LW,  32'h100, 32'hA5A5A5A5, 2, 3, 0, 32'h0,        1, 4'hF,    32'hA5A5A5A5});
    vt.push_back('{"lw_final",    1, 0, F3_LW,  32'h100, 32'h0,        1, 0, 1, 32'hA5A5A5A5, 0, 4'h0,    32'h0});
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_stall", stall, 0);
    rst = 0;
    @(posedge clk); #1;
    foreach (vt[i]) run(vt[i]);
    // reset arriving mid-fill must abort without validating the line
    ack_dly = 1000;
    txn_q.push_back('{1'b0, 32'h300, 4'hF, 32'h0});
    re = 1; we = 0; funct3 = F3_LW; addr = 32'h300;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("fill_mem_req", mem_req, 1);
    rst = 1; #1;
    chk("abort_mem_req", mem_req, 0);
    chk("abort_stall_miss", stall, 1);
    re = 0; #1;
    chk("abort_idle_stall", stall, 0);
    @(negedge clk); rst = 0;
    @(posedge clk); #1;
    run('{"post_abort_lw", 1, 0, F3_LW, 32'h100, 32'h0, 1, 2, 1, 32'hA5A5A5A5, 1, 4'hF, 32'h0});
    chk("txn_q_drained", txn_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_dcache.md
MEM_DCACHE -- requirements
Module: mem_dcache

Interface
REQ-001 Parameter SETS, default 64, number of direct-mapped one-word lines (power of two).
REQ-002 clk  in  1  clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 re  in  1  load in MEM stage (decoded from ResultSrcM upstream).
REQ-005 we  in  1  store in MEM stage (MemWriteM).
REQ-006 funct3  in  3  access size/sign: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
REQ-007 addr  in  32  byte address (ALUResultM).
REQ-008 wdata  in  32  store data, LSB-aligned (WriteDataM).
REQ-009 rdata  out  32  load result, extended per funct3.
REQ-010 stall  out  1  freezes PC and all pipeline registers while 1.
REQ-011 mem_req  out  1  backing-memory request, held until mem_ack.
REQ-012 mem_we  out  1  1 = write request, 0 = read request.
REQ-013 mem_addr  out  32  word-aligned address (addr[1:0] forced 0).
REQ-014 mem_wdata  out  32  store data shifted to byte lanes.
REQ-015 mem_wstrb  out  4  byte enables for writes.
REQ-016 mem_ack  in  1  one-cycle completion pulse from backing memory.
REQ-017 mem_rdata  in  32  read word, valid when mem_ack=1.

Function
REQ-018 Index = addr[log2(SETS)+1:2]; tag = remaining upper bits; hit = valid[index] and tag match.
REQ-019 FSM states IDLE, FILL, WRITE, DONE.
REQ-020 IDLE: we=1 -> WRITE; else re=1 and miss -> FILL; else stay; we has priority if re and we both 1.
REQ-021 FILL: mem_req=1, mem_we=0; on mem_ack write mem_rdata into line, set valid, store tag, -> DONE.
REQ-022 WRITE: mem_req=1, mem_we=1 (write-through, no-write-allocate); on mem_ack, if hit merge enabled bytes into line, -> DONE.
REQ-023 DONE: one cycle, -> IDLE unconditionally; no new request issued in DONE.
REQ-024 stall = 1 in IDLE when we=1 or (re=1 and miss); stall = 1 in FILL and WRITE; stall = 0 in DONE.
REQ-025 Load hit in IDLE: zero extra latency, stall=0, rdata combinational from line.
REQ-026 Load miss latency: stall cycles = 1 + cycles waiting for mem_ack; data returned from line in DONE.
REQ-027 rdata lane select: byte by addr[1:0], half by addr[1] (addr[0] ignored), word ignores addr[1:0]; sign-extend for 000/001, zero-extend for 100/101.
REQ-028 mem_wstrb: SB 0001<<addr[1:0], SH 0011<<(2*addr[1]), SW 1111; mem_wdata replicates byte/half into all lanes.
REQ-029 rdata undefined (don't care) when re=0; mem_addr/mem_wdata/mem_wstrb held stable while mem_req=1.
REQ-030 mem_ack outside FILL/WRITE ignored.

Reset
REQ-031 rst=1: state -> IDLE, all valid bits -> 0, mem_req -> 0, stall -> 0 (unless IDLE request present); tag/data arrays not reset.
REQ-032 rst asserted mid-FILL/WRITE aborts transaction; partial fill never sets valid.

Structure
REQ-033 FSM state enum and funct3 encoding constants live in shared package mem_pkg.
REQ-034 Load extraction/extension and store lane-steering in one combinational sub-module lsu_align.
REQ-035 Tag/data arrays as plain register arrays; valid as a SETS-bit vector.

Verification
REQ-036 After reset, LW 0x100, mem_ack after 3 cycles with 0xDEADBEEF -> stall 4 cycles, rdata=0xDEADBEEF in DONE, mem_req=0 after ack.
REQ-037 Repeat LW 0x100 -> stall=0, rdata=0xDEADBEEF same cycle, mem_req=0; LB 0x103 -> 0xFFFFFFDE; LBU 0x103 -> 0x000000DE; LH 0x102 -> 0xFFFFDEAD.
REQ-038 SB 0x101 wdata 0x55 (line valid) -> mem_we=1, mem_wstrb=0010, mem_addr=0x100, then LW 0x100 hits -> 0xDEAD55EF.
REQ-039 SW 0x500 on miss -> write issued, valid[index] stays 0; following LW 0x500 -> FILL issued.
REQ-040 LW 0x200 after 0x100 valid (same index, SETS=64) -> miss, FILL, line replaced; LW 0x100 then misses again.
REQ-041 rst asserted during FILL before mem_ack -> state IDLE, mem_req=0, next LW 0x100 misses.
